gpio_bank: RTL and testbench

- Parametrised memory-mapped GPIO controller that replaces the fixed LED/JB/JC direction-and-data logic in the SoC top.
- Provides N_PORTS ports of PORT_W pins each, with per-pin direction, atomic set/clear, synchronised input sampling, and per-pin rising/falling-edge interrupts.
- Sits on the mmio bus beside the uart and vga blocks.
- Tristate pad drivers stay in the top: per pin, pad = pad_oe ? pad_o : 'z.

---
 rtl/gpio_bank.sv | 188 ++++++++++++++++++
 tb/tb_gpio_bank.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO controller with N_PORTS ports of PORT_W pins.
//
// Each port has a 32-byte register window at port*0x20:
//   0x00 OUT      RW  output levels (pad_o)
//   0x04 DIR      RW  output enables (pad_oe), 1 = drive
//   0x08 IN       RO  synchronised pad_i
//   0x0C RISE_EN  RW  rising-edge interrupt enables
//   0x10 FALL_EN  RW  falling-edge interrupt enables
//   0x14 STATUS   R/W1C pending edge flags
//   0x18 SET      W   OUT |= wdata (reads 0)
//   0x1C CLR      W   OUT &= ~wdata (reads 0)
//
// Ports:
//   clk     system clock
//   rst     asynchronous active-low reset
//   en      one-cycle transaction request
//   rw      1 = write, 0 = read
//   addr    byte address, bits [1:0] ignored
//   wdata   write data, bits [31:PORT_W] ignored
//   rdata   registered read data, valid while ready = 1 (0 for writes)
//   ready   completion pulse, exactly one cycle after en
//   pad_i   raw pin levels, asynchronous to clk
//   pad_o   output levels, port p at bits [p*PORT_W +: PORT_W]
//   pad_oe  per-pin output enable
//   irq     OR of all pending STATUS bits
module gpio_bank #(
  parameter int N_PORTS     = 3,
  parameter int PORT_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        rw,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [31:0]                 wdata,
  output logic [31:0]                 rdata,
  output logic                        ready,
  input  logic [N_PORTS*PORT_W-1:0]   pad_i,
  output logic [N_PORTS*PORT_W-1:0]   pad_o,
  output logic [N_PORTS*PORT_W-1:0]   pad_oe,
  output logic                        irq
);

  localparam int NB = N_PORTS * PORT_W;

  typedef enum logic [2:0] {
    R_OUT    = 3'd0,
    R_DIR    = 3'd1,
    R_IN     = 3'd2,
    R_RISE   = 3'd3,
    R_FALL   = 3'd4,
    R_STATUS = 3'd5,
    R_SET    = 3'd6,
    R_CLR    = 3'd7
  } reg_e;

  // Per-port register state
  logic [PORT_W-1:0] out_q     [N_PORTS];
  logic [PORT_W-1:0] dir_q     [N_PORTS];
  logic [PORT_W-1:0] rise_en_q [N_PORTS];
  logic [PORT_W-1:0] fall_en_q [N_PORTS];
  logic [PORT_W-1:0] status_q  [N_PORTS];
  logic [PORT_W-1:0] status_d  [N_PORTS];
  logic [PORT_W-1:0] w1c_mask  [N_PORTS];

  // Input path: synchroniser chain, last stage is the IN register
  logic [NB-1:0] sync_q [SYNC_STAGES];
  logic [NB-1:0] in_w;
  logic [NB-1:0] prev_q;
  logic [NB-1:0] rise_w;
  logic [NB-1:0] fall_w;

  // Bus decode
  logic [31:0]       port_sel;
  reg_e              reg_sel;
  logic [PORT_W-1:0] wd;
  logic              port_ok;
  logic              bus_wr;
  logic              bus_rd;
  logic [31:0]       rd_val;

  // Collects bus bits that are deliberately ignored
  logic unused_bits;
  assign unused_bits = ^{wdata, addr[1:0]};

  // Port index is widened to 32 bits so a single-port build (ADDR_W = 5)
  // still decodes without a zero-width slice.
  always_comb begin
    port_sel = 32'(addr >> 5);
    reg_sel  = reg_e'(addr[4:2]);
    wd       = wdata[PORT_W-1:0];
    port_ok  = (port_sel < 32'(N_PORTS));
    bus_wr   = en & rw & port_ok;
    bus_rd   = en & ~rw & port_ok;
  end

  assign in_w   = sync_q[SYNC_STAGES-1];
  assign rise_w = in_w & ~prev_q;
  assign fall_w = ~in_w & prev_q;

  // Read mux, sampled from pre-write register values
  always_comb begin
    rd_val = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      if (bus_rd && port_sel == p) begin
        case (reg_sel)
          R_OUT:    rd_val[PORT_W-1:0] = out_q[p];
          R_DIR:    rd_val[PORT_W-1:0] = dir_q[p];
          R_IN:     rd_val[PORT_W-1:0] = in_w[p*PORT_W +: PORT_W];
          R_RISE:   rd_val[PORT_W-1:0] = rise_en_q[p];
          R_FALL:   rd_val[PORT_W-1:0] = fall_en_q[p];
          R_STATUS: rd_val[PORT_W-1:0] = status_q[p];
          default:  rd_val = '0;
        endcase
      end
    end
  end

  // STATUS next state: the clear is applied first so a same-cycle edge wins
  always_comb begin
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      w1c_mask[p] = '0;
      if (bus_wr && port_sel == p && reg_sel == R_STATUS) begin
        w1c_mask[p] = wd;
      end
      status_d[p] = (status_q[p] & ~w1c_mask[p])
                  | (rise_w[p*PORT_W +: PORT_W] & rise_en_q[p])
                  | (fall_w[p*PORT_W +: PORT_W] & fall_en_q[p]);
    end
  end

  // Pads and irq are pure wiring from flops
  always_comb begin
    pad_o  = '0;
    pad_oe = '0;
    irq    = 1'b0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      pad_o[p*PORT_W +: PORT_W]  = out_q[p];
      pad_oe[p*PORT_W +: PORT_W] = dir_q[p];
      irq = irq | (|status_q[p]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready  <= 1'b0;
      rdata  <= '0;
      prev_q <= '0;
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        out_q[p]     <= '0;
        dir_q[p]     <= '0;
        rise_en_q[p] <= '0;
        fall_en_q[p] <= '0;
        status_q[p]  <= '0;
      end
    end else begin
      ready <= en;
      rdata <= rd_val;

      sync_q[0] <= pad_i;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= in_w;

      for (int unsigned p = 0; p < N_PORTS; p++) begin
        status_q[p] <= status_d[p];
        if (bus_wr && port_sel == p) begin
          case (reg_sel)
            R_OUT:   out_q[p]     <= wd;
            R_DIR:   dir_q[p]     <= wd;
            R_RISE:  rise_en_q[p] <= wd;
            R_FALL:  fall_en_q[p] <= wd;
            R_SET:   out_q[p]     <= out_q[p] | wd;
            R_CLR:   out_q[p]     <= out_q[p] & ~wd;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed table plus randomized traffic for gpio_bank,
// checked against a transaction-level reference model.
module tb_gpio_bank;

  localparam int NP = 3;
  localparam int PW = 16;
  localparam int SS = 2;
  localparam int AW = 8;
  localparam int NB = NP * PW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          rw = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          ready;
  logic [NB-1:0] pad_i = '0;
  logic [NB-1:0] pad_o;
  logic [NB-1:0] pad_oe;
  logic          irq;

  always #5 clk = ~clk;

  gpio_bank #(
    .N_PORTS(NP),
    .PORT_W(PW),
    .SYNC_STAGES(SS),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .rw(rw),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .ready(ready),
    .pad_i(pad_i),
    .pad_o(pad_o),
    .pad_oe(pad_oe),
    .irq(irq)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: register file per port plus a delay line of pad samples.
  // hist[k] is the pad_i value sampled k edges ago; IN is hist[SS-1].
  logic [PW-1:0] m_out [NP];
  logic [PW-1:0] m_dir [NP];
  logic [PW-1:0] m_ren [NP];
  logic [PW-1:0] m_fen [NP];
  logic [PW-1:0] m_st  [NP];
  logic [NB-1:0] hist  [SS+1];
  logic [31:0]   m_rdata;
  logic          m_ready;

  task automatic model_reset();
    m_ready = 1'b0;
    m_rdata = '0;
    for (int i = 0; i < NP; i++) begin
      m_out[i] = '0; m_dir[i] = '0; m_ren[i] = '0; m_fen[i] = '0; m_st[i] = '0;
    end
    for (int i = 0; i <= SS; i++) hist[i] = '0;
  endtask

  task automatic model_step();
    int mp, mr;
    logic [PW-1:0] mwd, mmask;
    logic [NB-1:0] mrise, mfall;
    if (!rst) begin
      model_reset();
      return;
    end
    mp  = int'(addr) / 32;
    mr  = (int'(addr) % 32) / 4;
    mwd = wdata[PW-1:0];
    mrise = hist[SS-1] & ~hist[SS];
    mfall = ~hist[SS-1] & hist[SS];
    m_ready = en;
    m_rdata = '0;
    if (en && !rw && mp < NP) begin
      case (mr)
        0: m_rdata = 32'(m_out[mp]);
        1: m_rdata = 32'(m_dir[mp]);
        2: m_rdata = 32'(hist[SS-1][mp*PW +: PW]);
        3: m_rdata = 32'(m_ren[mp]);
        4: m_rdata = 32'(m_fen[mp]);
        5: m_rdata = 32'(m_st[mp]);
        default: m_rdata = '0;
      endcase
    end
    for (int q = 0; q < NP; q++) begin
      mmask = (en && rw && mp == q && mr == 5) ? mwd : '0;
      m_st[q] = (m_st[q] & ~mmask) | (mrise[q*PW +: PW] & m_ren[q])
              | (mfall[q*PW +: PW] & m_fen[q]);
    end
    if (en && rw && mp < NP) begin
      case (mr)
        0: m_out[mp] = mwd;
        1: m_dir[mp] = mwd;
        3: m_ren[mp] = mwd;
        4: m_fen[mp] = mwd;
        6: m_out[mp] = m_out[mp] | mwd;
        7: m_out[mp] = m_out[mp] & ~mwd;
        default: ;
      endcase
    end
    for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = pad_i;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [NB-1:0] e_po, e_oe;
    logic e_irq;
    e_irq = 1'b0;
    for (int q = 0; q < NP; q++) begin
      e_po[q*PW +: PW] = m_out[q];
      e_oe[q*PW +: PW] = m_dir[q];
      e_irq = e_irq | (|m_st[q]);
    end
    chk("m_ready", 64'(ready), 64'(m_ready));
    chk("m_rdata", 64'(rdata), 64'(m_rdata));
    chk("m_pad_o", 64'(pad_o), 64'(e_po));
    chk("m_pad_oe", 64'(pad_oe), 64'(e_oe));
    chk("m_irq", 64'(irq), 64'(e_irq));
  endtask

  // One clock: model advances on the same edge as the DUT, compare on negedge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic bus(input logic w, input logic [AW-1:0] a, input logic [31:0] d);
    en = 1'b1; rw = w; addr = a; wdata = d;
    tick();
    en = 1'b0;
  endtask

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   rd;
    logic [PW-1:0] po;
    logic [PW-1:0] poe;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r64;
    int port, rg;

    vecs[0]  = '{1'b0, 8'h04, 32'h0,        32'h0,    16'h0,    16'h0};
    vecs[1]  = '{1'b0, 8'h14, 32'h0,        32'h0,    16'h0,    16'h0};
    vecs[2]  = '{1'b0, 8'h24, 32'h0,        32'h0,    16'h0,    16'h0};
    vecs[3]  = '{1'b0, 8'h34, 32'h0,        32'h0,    16'h0,    16'h0};
    vecs[4]  = '{1'b0, 8'h44, 32'h0,        32'h0,    16'h0,    16'h0};
    vecs[5]  = '{1'b0, 8'h54, 32'h0,        32'h0,    16'h0,    16'h0};
    vecs[6]  = '{1'b1, 8'h04, 32'h00FF,     32'h0,    16'h0,    16'h00FF};
    vecs[7]  = '{1'b1, 8'h00, 32'h1234,     32'h0,    16'h1234, 16'h00FF};
    vecs[8]  = '{1'b1, 8'h18, 32'h0001,     32'h0,    16'h1235, 16'h00FF};
    vecs[9]  = '{1'b1, 8'h1C, 32'h0030,     32'h0,    16'h1205, 16'h00FF};
    vecs[10] = '{1'b0, 8'h00, 32'h0,        32'h1205, 16'h1205, 16'h00FF};
    vecs[11] = '{1'b0, 8'h18, 32'h0,        32'h0,    16'h1205, 16'h00FF};
    vecs[12] = '{1'b0, 8'h1C, 32'h0,        32'h0,    16'h1205, 16'h00FF};
    vecs[13] = '{1'b0, 8'h04, 32'h0,        32'h00FF, 16'h1205, 16'h00FF};
    vecs[14] = '{1'b1, 8'h00, 32'hABCD1205, 32'h0,    16'h1205, 16'h00FF};
    vecs[15] = '{1'b0, 8'h00, 32'h0,        32'h1205, 16'h1205, 16'h00FF};
    vecs[16] = '{1'b1, 8'h08, 32'hFFFF,     32'h0,    16'h1205, 16'h00FF};
    vecs[17] = '{1'b0, 8'h08, 32'h0,        32'h0,    16'h1205, 16'h00FF};
    vecs[18] = '{1'b1, 8'h60, 32'hFFFFFFFF, 32'h0,    16'h1205, 16'h00FF};
    vecs[19] = '{1'b0, 8'h60, 32'h0,        32'h0,    16'h1205, 16'h00FF};
    vecs[20] = '{1'b0, 8'h61, 32'h0,        32'h0,    16'h1205, 16'h00FF};
    vecs[21] = '{1'b0, 8'h03, 32'h0,        32'h1205, 16'h1205, 16'h00FF};

    // Power-on reset
    model_reset();
    tick();
    tick();
    rst = 1'b1;
    chk("rst_pad_o", 64'(pad_o), 64'h0);
    chk("rst_pad_oe", 64'(pad_oe), 64'h0);
    chk("rst_irq", 64'(irq), 64'h0);
    chk("rst_ready", 64'(ready), 64'h0);

    // Directed register table
    for (int i = 0; i < NV; i++) begin
      bus(vecs[i].rw, vecs[i].addr, vecs[i].wdata);
      chk("tbl_ready", 64'(ready), 64'h1);
      chk("tbl_rdata", 64'(rdata), 64'(vecs[i].rd));
      chk("tbl_pad_o", 64'(pad_o[PW-1:0]), 64'(vecs[i].po));
      chk("tbl_pad_oe", 64'(pad_oe[PW-1:0]), 64'(vecs[i].poe));
    end
    tick();
    chk("idle_ready", 64'(ready), 64'h0);

    // Rising edge on port1 pin2: IN after 2 cycles, STATUS/irq after 3
    bus(1'b1, 8'h2C, 32'h4);
    pad_i[PW+2] = 1'b1;
    tick();
    chk("edge_irq_c1", 64'(irq), 64'h0);
    bus(1'b0, 8'h28, 32'h0);
    chk("in_c2", 64'(rdata), 64'h0);
    chk("edge_irq_c2", 64'(irq), 64'h0);
    bus(1'b0, 8'h28, 32'h0);
    chk("in_c3", 64'(rdata), 64'h4);
    chk("edge_irq_c3", 64'(irq), 64'h1);
    bus(1'b0, 8'h34, 32'h0);
    chk("status_rd", 64'(rdata), 64'h4);
    bus(1'b1, 8'h34, 32'h4);
    chk("w1c_irq", 64'(irq), 64'h0);
    pad_i[PW+2] = 1'b0;
    repeat (4) tick();
    chk("fall_no_irq", 64'(irq), 64'h0);
    bus(1'b0, 8'h34, 32'h0);
    chk("fall_status", 64'(rdata), 64'h0);

    // W1C collides with a fresh enabled edge: set wins
    pad_i[PW+2] = 1'b1;
    repeat (3) tick();
    chk("pend_irq", 64'(irq), 64'h1);
    pad_i[PW+2] = 1'b0;
    repeat (3) tick();
    chk("pend_hold", 64'(irq), 64'h1);
    pad_i[PW+2] = 1'b1;
    tick();
    tick();
    bus(1'b1, 8'h34, 32'h4);
    chk("w1c_vs_edge_irq", 64'(irq), 64'h1);
    bus(1'b0, 8'h34, 32'h0);
    chk("w1c_vs_edge_st", 64'(rdata), 64'h4);

    // Back-to-back transactions, including an out-of-range port
    for (int i = 0; i < 4; i++) begin
      en = 1'b1; rw = 1'b0; addr = AW'(i * 32); wdata = '0;
      tick();
      chk("b2b_ready", 64'(ready), 64'h1);
    end
    en = 1'b0;
    tick();
    chk("b2b_done", 64'(ready), 64'h0);

    // Reset with a transaction in flight, OUT all ones and STATUS pending
    bus(1'b1, 8'h00, 32'hFFFF);
    chk("pre_rst_pad_o", 64'(pad_o[PW-1:0]), 64'hFFFF);
    chk("pre_rst_irq", 64'(irq), 64'h1);
    en = 1'b1; rw = 1'b0; addr = 8'h00;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("arst_pad_o", 64'(pad_o), 64'h0);
    chk("arst_pad_oe", 64'(pad_oe), 64'h0);
    chk("arst_irq", 64'(irq), 64'h0);
    chk("arst_ready", 64'(ready), 64'h0);
    chk("arst_rdata", 64'(rdata), 64'h0);
    tick();
    chk("arst_dropped", 64'(ready), 64'h0);
    en = 1'b0;
    rst = 1'b1;
    // pin 18 is still high: its rise after release is lost with enables at 0
    repeat (5) tick();
    chk("post_rst_irq", 64'(irq), 64'h0);
    bus(1'b0, 8'h34, 32'h0);
    chk("post_rst_status", 64'(rdata), 64'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      en    = 1'($urandom_range(0, 1));
      rw    = 1'($urandom_range(0, 1));
      port  = int'($urandom_range(0, 4));
      rg    = int'($urandom_range(0, 7));
      addr  = AW'(port * 32 + rg * 4 + int'($urandom_range(0, 3)));
      wdata = $urandom();
      if ($urandom_range(0, 3) == 0) begin
        r64   = {$urandom(), $urandom()};
        pad_i = pad_i ^ r64[NB-1:0];
      end
      tick();
    end
    en = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
